// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// The optional overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // The digit counter is four bits wide, so at most sixteen digits fit.
    function automatic bit digits_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0)
               && ((width / digit) <= 16);
    endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// Combinational ripple of DIGIT full-subtractor cells.
// Computes diff = a - b - b_in for one digit and returns the borrow out.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             b_in,
    output logic [DIGIT-1:0] diff,
    output logic             b_out
);

    logic [DIGIT:0] borrow;

    assign borrow[0] = b_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign b_out = borrow[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - b_in, DIGIT bits per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam logic [3:0] LAST_CNT = 4'(NUM_DIGITS - 1);

    if (!digits_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_subtractor: DIGIT must divide WIDTH with at most 16 digits");
    end

    sub_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0] a_dig, b_dig, dig_diff;
    logic             dig_bout;
    logic [WIDTH-1:0] diff_shifted;

    assign a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];

    digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_dig),
        .b     (b_dig),
        .b_in  (borrow_q),
        .diff  (dig_diff),
        .b_out (dig_bout)
    );

    // New digits enter at the MSB so the full result is aligned after the last digit.
    if (DIGIT == WIDTH) begin : g_full_shift
        assign diff_shifted = dig_diff;
    end else begin : g_part_shift
        assign diff_shifted = {dig_diff, diff_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    cnt_d    = '0;
                end
            end
            BUSY: begin
                diff_d   = diff_shifted;
                borrow_d = dig_bout;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    b_out_d = dig_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (dig_diff[DIGIT-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor in three shapes: 16/4, 1/1 and 16/16.
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_s = '0;
    logic [15:0] b_s = '0;
    logic        bin_s = 1'b0;
    logic        in_valid_s = 1'b0;
    logic        out_ready_s = 1'b0;
    int          sel = 0;

    int checks_total = 0;
    int checks_passed = 0;

    logic        in_ready0, out_valid0, b_out0;
    logic [15:0] diff0;
    logic        in_ready1, out_valid1, b_out1;
    logic [0:0]  diff1;
    logic        in_ready2, out_valid2, b_out2;
    logic [15:0] diff2;
    logic        ovf0, ovf1, ovf2;

    logic        obs_in_ready, obs_out_valid, obs_b_out, obs_ovf;
    logic [15:0] obs_diff;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s && (sel == 0)),
        .in_ready  (in_ready0),
        .a         (a_s),
        .b         (b_s),
        .b_in      (bin_s),
        .out_valid (out_valid0),
        .out_ready (out_ready_s),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf0),
`endif
        .diff      (diff0),
        .b_out     (b_out0)
    );

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s && (sel == 1)),
        .in_ready  (in_ready1),
        .a         (a_s[0:0]),
        .b         (b_s[0:0]),
        .b_in      (bin_s),
        .out_valid (out_valid1),
        .out_ready (out_ready_s),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf1),
`endif
        .diff      (diff1),
        .b_out     (b_out1)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(16)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s && (sel == 2)),
        .in_ready  (in_ready2),
        .a         (a_s),
        .b         (b_s),
        .b_in      (bin_s),
        .out_valid (out_valid2),
        .out_ready (out_ready_s),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf2),
`endif
        .diff      (diff2),
        .b_out     (b_out2)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    // Route the selected instance onto one set of observation signals.
    always_comb begin
        obs_in_ready  = in_ready0;
        obs_out_valid = out_valid0;
        obs_b_out     = b_out0;
        obs_diff      = diff0;
        obs_ovf       = ovf0;
        if (sel == 1) begin
            obs_in_ready  = in_ready1;
            obs_out_valid = out_valid1;
            obs_b_out     = b_out1;
            obs_diff      = {15'd0, diff1};
            obs_ovf       = ovf1;
        end else if (sel == 2) begin
            obs_in_ready  = in_ready2;
            obs_out_valid = out_valid2;
            obs_b_out     = b_out2;
            obs_diff      = diff2;
            obs_ovf       = ovf2;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (sel=%0d, t=%0t)",
                     tag, got, exp, sel, $time);
        end
    endtask

    // Offer one operation, then count edges until out_valid rises (bounded).
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic bv_in, input int exp_lat);
        int lat;
        a_s = av;
        b_s = bv;
        bin_s = bv_in;
        in_valid_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        lat = 0;
        while (!obs_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, exp_lat);
    endtask

    task automatic releaseResult();
        out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        checkOutput("out_valid_after_take", obs_out_valid, 0);
        checkOutput("in_ready_after_take", obs_in_ready, 1);
    endtask

    // Reference model sized by the currently selected instance.
    task automatic checkModel(input string tag, input logic [15:0] av,
                              input logic [15:0] bv, input logic bv_in);
        logic [16:0] full;
        logic [15:0] exp_diff;
        logic        exp_bout, exp_ovf;
        if (sel == 1) begin
            full     = {16'd0, av[0]} - {16'd0, bv[0]} - {16'd0, bv_in};
            exp_diff = {15'd0, full[0]};
            exp_bout = full[16];
            exp_ovf  = (av[0] != bv[0]) && (full[0] != av[0]);
        end else begin
            full     = {1'b0, av} - {1'b0, bv} - {16'd0, bv_in};
            exp_diff = full[15:0];
            exp_bout = full[16];
            exp_ovf  = (av[15] != bv[15]) && (full[15] != av[15]);
        end
        checkOutput({tag, "_diff"}, obs_diff, exp_diff);
        checkOutput({tag, "_bout"}, obs_b_out, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({tag, "_ovf"}, obs_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("[TB] unexpected unknown in overflow model");
`endif
    endtask

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        logic        bin;
    } vec_t;

    vec_t b2b[5];

    initial begin
        b2b[0] = '{16'hFFFF, 16'h0001, 1'b1};
        b2b[1] = '{16'h1234, 16'h5678, 1'b0};
        b2b[2] = '{16'h0000, 16'hFFFF, 1'b0};
        b2b[3] = '{16'h8000, 16'h7FFF, 1'b1};
        b2b[4] = '{16'hAAAA, 16'h5555, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        sel = 0;
        checkOutput("rst_in_ready", obs_in_ready, 1);
        checkOutput("rst_out_valid", obs_out_valid, 0);
        checkOutput("rst_diff", obs_diff, 16'h0000);
        checkOutput("rst_bout", obs_b_out, 0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("rst_ovf", obs_ovf, 0);
`endif
        sel = 2;
        checkOutput("rst_in_ready_w16", obs_in_ready, 1);
        checkOutput("rst_diff_w16", obs_diff, 16'h0000);

        // 16-bit, 4-bit digits: basic, borrow-in wrap and overflow cases.
        sel = 0;
        applyStimulus(16'h0005, 16'h0003, 1'b0, 4);
        checkOutput("basic_diff", obs_diff, 16'h0002);
        checkOutput("basic_bout", obs_b_out, 0);
        releaseResult();

        applyStimulus(16'h0000, 16'h0000, 1'b1, 4);
        checkOutput("wrap_diff", obs_diff, 16'hFFFF);
        checkOutput("wrap_bout", obs_b_out, 1);
        releaseResult();

`ifdef SERIAL_SUB_OVF_EN
        applyStimulus(16'h8000, 16'h0001, 1'b0, 4);
        checkOutput("ovf_diff", obs_diff, 16'h7FFF);
        checkOutput("ovf_bout", obs_b_out, 0);
        checkOutput("ovf_flag", obs_ovf, 1);
        releaseResult();
`endif

        // Result must hold while the consumer stalls and new offers are ignored.
        applyStimulus(16'h00F0, 16'h0010, 1'b0, 4);
        for (int i = 0; i < 5; i++) begin
            in_valid_s = ~in_valid_s;
            a_s = 16'($urandom);
            b_s = 16'($urandom);
            bin_s = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold_out_valid", obs_out_valid, 1);
            checkOutput("hold_in_ready", obs_in_ready, 0);
            checkOutput("hold_diff", obs_diff, 16'h00E0);
            checkOutput("hold_bout", obs_b_out, 0);
        end
        in_valid_s = 1'b0;
        releaseResult();
        @(posedge clk);
        #1;
        checkOutput("no_capture_in_ready", obs_in_ready, 1);

        // Reset during the second BUSY cycle aborts without a result.
        a_s = 16'h0F0F;
        b_s = 16'h0101;
        bin_s = 1'b0;
        in_valid_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_in_ready", obs_in_ready, 1);
        checkOutput("abort_out_valid", obs_out_valid, 0);
        checkOutput("abort_diff", obs_diff, 16'h0000);
        applyStimulus(16'h1234, 16'h0234, 1'b0, 4);
        checkOutput("after_abort_diff", obs_diff, 16'h1000);
        checkOutput("after_abort_bout", obs_b_out, 0);
        releaseResult();

        // 1-bit instance against the full-subtractor truth table.
        sel = 1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            applyStimulus({15'd0, v[2]}, {15'd0, v[1]}, v[0], 1);
            checkModel("fs", {15'd0, v[2]}, {15'd0, v[1]}, v[0]);
            releaseResult();
        end
        applyStimulus(16'h0000, 16'h0001, 1'b1, 1);
        checkOutput("fs011_diff", obs_diff, 16'h0000);
        checkOutput("fs011_bout", obs_b_out, 1);
        releaseResult();
        applyStimulus(16'h0001, 16'h0000, 1'b0, 1);
        checkOutput("fs100_diff", obs_diff, 16'h0001);
        checkOutput("fs100_bout", obs_b_out, 0);
        releaseResult();

        // Full-width digit: back-to-back with out_ready held, one result per 3 cycles.
        sel = 2;
        out_ready_s = 1'b1;
        in_valid_s = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_s = b2b[k].av;
            b_s = b2b[k].bv;
            bin_s = b2b[k].bin;
            checkOutput("b2b_in_ready", obs_in_ready, 1);
            @(posedge clk);
            #1;
            checkOutput("b2b_busy_out_valid", obs_out_valid, 0);
            @(posedge clk);
            #1;
            checkOutput("b2b_done_out_valid", obs_out_valid, 1);
            checkModel("b2b", b2b[k].av, b2b[k].bv, b2b[k].bin);
            @(posedge clk);
            #1;
        end
        in_valid_s = 1'b0;
        out_ready_s = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b_final_idle", obs_in_ready, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor. It computes `diff = a - b - b_in` over a WIDTH-bit operand, DIGIT bits per clock, LSB digit first, with a registered borrow chained between digits. It replaces the single-bit combinational full subtractor wherever wide operands must be subtracted with a small area footprint. Operands arrive and results leave over valid/ready handshakes.

## Interface
- `WIDTH`, default 16, is the operand and result width in bits (>= 1).
- `DIGIT`, default 4, is the number of bits processed per cycle. It must divide WIDTH, and 1 <= DIGIT <= WIDTH.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operands are present.
- `in_ready` output, 1 bit: the block accepts operands. High only in IDLE.
- `a` input, WIDTH bits: minuend.
- `b` input, WIDTH bits: subtrahend.
- `b_in` input, 1 bit: borrow in.
- `out_valid` output, 1 bit: the result is present.
- `out_ready` input, 1 bit: the consumer takes the result.
- `diff` output, WIDTH bits: the difference.
- `b_out` output, 1 bit: borrow out.
- `ovf` output, 1 bit: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- NUM_DIGITS = WIDTH/DIGIT. A 4-bit digit counter counts 0..NUM_DIGITS-1.
- FSM states:
  - IDLE → BUSY on `in_valid && in_ready`. This edge captures `a`, `b` and `b_in` into registers and clears the counter.
  - BUSY → each cycle subtracts digit[count] of the captured a and b with the borrow register. The result digit shifts into `diff` from the MSB side (right shift by DIGIT). The borrow register updates and the counter increments.
  - BUSY → DONE on the edge that processes count = NUM_DIGITS-1.
  - DONE → IDLE on `out_ready`.
- Arithmetic:
  - `diff` = (a - b - b_in) mod 2^WIDTH.
  - `b_out` = 1 iff a < b + b_in (unsigned).
  - `ovf` = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- `in_valid` is ignored outside IDLE. Operand inputs may change freely after the capture edge.
- `diff`, `b_out` and `ovf` hold stable while `out_valid` is high. They keep their last value after the DONE→IDLE transition until overwritten by the next operation's BUSY shifts.
- Reset at any point, including mid-BUSY or DONE, aborts the operation. No result is emitted.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `out_valid` = 0.
  - `diff` = 0, `b_out` = 0, `ovf` = 0.
  - counter = 0, borrow register = 0.
- Latency: with acceptance at edge T0, `out_valid` rises after edge T0+NUM_DIGITS. With DIGIT = WIDTH, this is one cycle.
- Throughput: one operation per NUM_DIGITS+2 cycles with `out_ready` held high. Accept and complete never overlap.
- `in_ready` and `out_valid` decode directly from registered state. There are no combinational paths from inputs to handshake outputs.
- `out_ready` is sampled only in DONE. If `out_ready` is high on the first DONE cycle, the transfer occurs on that edge.
- `rst` takes priority over every transition on the same edge.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` registers on the final BUSY edge, from the captured sign bits and the final `diff[MSB]`.
- `SERIAL_SUB_OVF_EN` undefined:
  - The port is absent and there is no overflow logic.
  - All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the state enum `sub_state_t` (IDLE, BUSY, DONE);
  - the function `num_digits(WIDTH, DIGIT)`;
  - the elaboration check that DIGIT divides WIDTH.
- Sub-module `digit_subtractor` (parameter DIGIT) is a combinational ripple of DIGIT full-subtractor cells. Its ports are `a`, `b`, `b_in` → `diff`, `b_out`. It is instantiated once.
- The top level contains the FSM, the counter, the operand registers, the borrow register and the result shift register.

## Test plan
- WIDTH=16, DIGIT=4. a=0x0005, b=0x0003, b_in=0 → `diff`=0x0002, `b_out`=0, and `out_valid` rises 4 cycles after accept.
- a=0x0000, b=0x0000, b_in=1 → `diff`=0xFFFF, `b_out`=1. With the macro, a=0x8000, b=0x0001 → `diff`=0x7FFF, `b_out`=0, `ovf`=1.
- Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and the operands → `out_valid`=1, outputs unchanged, `in_ready`=0, and no new capture.
- Assert `rst` on the second BUSY cycle → next cycle `in_ready`=1, `out_valid`=0, `diff`=0. A following a=0x1234, b=0x0234 → `diff`=0x1000.
- WIDTH=1, DIGIT=1, all 8 (a, b, b_in) combinations → match the full-subtractor truth table, e.g. (0,1,1) gives `diff`=0, `b_out`=1 and (1,0,0) gives `diff`=1, `b_out`=0. Latency is 1.
- WIDTH=16, DIGIT=16, back-to-back operations with `out_ready`=1 → a result every 3 cycles, equal to the reference model `a - b - b_in`.
